// File: rtl/bcd_to_bin_pkg.sv
// Shared constants and types for the BCD-to-binary converter.
// BCD_W/BIN_W size the shift registers, ITERS is the number of
// shift/adjust steps (one per result bit), and the digit constants
// drive both the input validity check and the per-nibble adjust.
package bcd_to_bin_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam int BCD_W = 12;
    localparam int BIN_W = 10;
    localparam int ITERS = 10;

    localparam bcd_digit_t DIGIT_MAX  = 4'd9;
    localparam bcd_digit_t ADJ_THRESH = 4'd8;
    localparam bcd_digit_t ADJ_VAL    = 4'd3;

    // A digit above 9 cannot come from decimal entry; flag it.
    function automatic logic digit_bad(input bcd_digit_t d);
        return d > DIGIT_MAX;
    endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// Per-nibble correction for reverse double-dabble.
// After a right shift, a BCD nibble that reads 8 or more received a
// bit worth 10 from the digit above, but binary weight makes it 8;
// subtracting 3 restores the decimal meaning (16/2 = 8 -> 10/2 = 5).
// Ports:
//   raw - shifted nibble
//   adj - corrected nibble
module bcd_digit_adjust
    import bcd_to_bin_pkg::*;
(
    input  logic [3:0] raw,
    output logic [3:0] adj
);

    assign adj = (raw >= ADJ_THRESH) ? raw - ADJ_VAL : raw;

endmodule

// File: rtl/bcd_to_bin.sv
// Sequential 3-digit packed BCD to 10-bit binary converter.
// A request is captured when in_valid and in_ready are both high; the
// converter then performs ten shift-right/adjust steps, one per clock,
// and pulses out_valid for one cycle with the result in Bout. Inputs
// with any digit above 9 produce Bout = 0 and err = 1.
// Ports:
//   clk       - rising-edge clock
//   rst_n     - asynchronous active-low reset
//   in_valid  - conversion request
//   in_ready  - idle, request will be accepted
//   huns/tens/units - BCD digits
//   Bout      - binary result, held until next completion
//   out_valid - one-cycle completion pulse
//   err       - illegal digit seen in the accepted request
module bcd_to_bin
    import bcd_to_bin_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] huns,
    input  logic [3:0] tens,
    input  logic [3:0] units,
    output logic [9:0] Bout,
    output logic       out_valid,
    output logic       err
);

    localparam logic STATE_IDLE = 1'b0;
    localparam logic STATE_BUSY = 1'b1;

    localparam logic [3:0] LAST_ITER = 4'(ITERS - 1);

    logic                   state;
    logic [3:0]             iter_cnt;
    logic [BCD_W-1:0]       bcd_reg;
    logic [BIN_W-1:0]       bin_reg;
    logic                   invalid;

    logic [BCD_W+BIN_W-1:0] shifted;
    logic [BCD_W-1:0]       bcd_next;
    logic [BIN_W-1:0]       bin_next;
    logic                   accept;

    // Shift the whole {bcd, bin} pair, then correct each BCD nibble;
    // the registers capture the adjusted value once per clock.
    assign shifted  = {bcd_reg, bin_reg} >> 1;
    assign bin_next = shifted[BIN_W-1:0];

    bcd_digit_adjust u_adj_units (
        .raw (shifted[BIN_W +: 4]),
        .adj (bcd_next[3:0])
    );

    bcd_digit_adjust u_adj_tens (
        .raw (shifted[BIN_W + 4 +: 4]),
        .adj (bcd_next[7:4])
    );

    bcd_digit_adjust u_adj_huns (
        .raw (shifted[BIN_W + 8 +: 4]),
        .adj (bcd_next[11:8])
    );

    assign in_ready = (state == STATE_IDLE);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= STATE_IDLE;
            iter_cnt  <= 4'd0;
            bcd_reg   <= '0;
            bin_reg   <= '0;
            invalid   <= 1'b0;
            Bout      <= '0;
            out_valid <= 1'b0;
            err       <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                STATE_IDLE: begin
                    if (accept) begin
                        bcd_reg  <= {huns, tens, units};
                        bin_reg  <= '0;
                        invalid  <= digit_bad(huns) || digit_bad(tens) || digit_bad(units);
                        iter_cnt <= 4'd0;
                        state    <= STATE_BUSY;
                    end
                end
                default: begin
                    bcd_reg <= bcd_next;
                    bin_reg <= bin_next;
                    if (iter_cnt == LAST_ITER) begin
                        // Final step: publish this step's binary value directly,
                        // so the result appears on the same edge as the last shift.
                        Bout      <= invalid ? '0 : bin_next;
                        err       <= invalid;
                        out_valid <= 1'b1;
                        iter_cnt  <= 4'd0;
                        state     <= STATE_IDLE;
                    end else begin
                        iter_cnt <= iter_cnt + 4'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_to_bin.sv
module tb_bcd_to_bin;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] huns = 4'd0;
    logic [3:0] tens = 4'd0;
    logic [3:0] units = 4'd0;
    logic [9:0] Bout;
    logic       out_valid;
    logic       err;

    int n_assert = 0;
    int n_fail   = 0;

    bcd_to_bin dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .huns      (huns),
        .tens      (tens),
        .units     (units),
        .Bout      (Bout),
        .out_valid (out_valid),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_assert++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: decimal value and timing rules only.
    // A request seen at edge c with c >= ready_at is accepted; its result
    // appears after edge c+10 and the next request is possible at edge c+11.
    int         m_cyc = 0;
    int         m_ready_at = 0;
    int         m_due = 0;
    bit         m_pending = 0;
    int         m_pend_val = 0;
    bit         m_pend_err = 0;
    bit         m_ov = 0;
    int         m_bout = 0;
    bit         m_err = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cyc = 0; m_ready_at = 0; m_due = 0; m_pending = 0;
            m_ov = 0; m_bout = 0; m_err = 0;
        end else begin
            m_cyc++;
            m_ov = 0;
            if (m_pending && m_cyc == m_due) begin
                m_ov = 1; m_pending = 0;
                m_bout = m_pend_err ? 0 : m_pend_val;
                m_err = m_pend_err;
            end
            if (in_valid && m_cyc >= m_ready_at) begin
                m_pend_err = (huns > 9) || (tens > 9) || (units > 9);
                m_pend_val = 100 * int'(huns) + 10 * int'(tens) + int'(units);
                m_pending  = 1;
                m_due      = m_cyc + 10;
                m_ready_at = m_cyc + 11;
            end
        end
    end

    // Compare every cycle, on the falling edge.
    always @(negedge clk) begin
        chk("model out_valid", int'(out_valid), int'(m_ov));
        chk("model in_ready", int'(in_ready), int'(m_cyc + 1 >= m_ready_at));
        chk("model Bout", int'(Bout), m_bout);
        chk("model err", int'(err), int'(m_err));
    end

    // One-shot request; waits for completion and pins literal results.
    task automatic conv(input logic [3:0] h, input logic [3:0] t, input logic [3:0] u,
                        input int exp_bout, input int exp_err, input string nm);
        int lat;
        @(negedge clk); #1;
        huns = h; tens = t; units = u; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        huns = 4'($urandom_range(0, 15)); tens = 4'($urandom_range(0, 15));
        units = 4'($urandom_range(0, 15));
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({nm, " latency"}, lat, 10);
        chk({nm, " Bout"}, int'(Bout), exp_bout);
        chk({nm, " err"}, int'(err), exp_err);
        @(posedge clk); #1;
        chk({nm, " pulse width"}, int'(out_valid), 0);
        chk({nm, " Bout hold"}, int'(Bout), exp_bout);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int gap;
        int pulses;

        #3;
        chk("reset Bout", int'(Bout), 0);
        chk("reset out_valid", int'(out_valid), 0);
        chk("reset err", int'(err), 0);
        chk("reset in_ready", int'(in_ready), 1);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;

        conv(4'd2, 4'd0, 4'd0, 200, 0, "200");
        conv(4'd9, 4'd9, 4'd9, 999, 0, "999");
        conv(4'd0, 4'd6, 4'd4, 64, 0, "64");
        conv(4'd0, 4'd9, 4'd5, 95, 0, "95");
        conv(4'd0, 4'd0, 4'd0, 0, 0, "zero");
        conv(4'd0, 4'd10, 4'd5, 0, 1, "bad digit");
        conv(4'd1, 4'd2, 4'd3, 123, 0, "after bad");
        conv(4'd9, 4'd0, 4'd9, 909, 0, "909");

        // in_valid held high across two requests with churning inputs.
        @(negedge clk); #1;
        huns = 4'd3; tens = 4'd4; units = 4'd5; in_valid = 1'b1;
        @(posedge clk); #1;
        gap = 0;
        while (!out_valid && gap < 20) begin
            if (gap == 2) begin huns = 4'd6; tens = 4'd6; units = 4'd6; end
            if (gap == 5) begin huns = 4'd7; tens = 4'd8; units = 4'd9; end
            @(posedge clk); #1;
            gap++;
        end
        chk("held first latency", gap, 10);
        chk("held first Bout", int'(Bout), 345);
        chk("held in_ready at pulse", int'(in_ready), 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        huns = 4'd1; tens = 4'd1; units = 4'd1;
        gap = 1;
        while (!out_valid && gap < 25) begin
            @(posedge clk); #1;
            gap++;
        end
        chk("held spacing", gap, 11);
        chk("held second Bout", int'(Bout), 789);

        // Reset in the middle of a 9/9/9 conversion.
        @(negedge clk); #1;
        huns = 4'd9; tens = 4'd9; units = 4'd9; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort Bout", int'(Bout), 0);
        chk("abort out_valid", int'(out_valid), 0);
        chk("abort err", int'(err), 0);
        chk("abort in_ready", int'(in_ready), 1);
        @(negedge clk); #1 rst_n = 1'b1;
        pulses = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (out_valid) pulses++;
        end
        chk("abort no pulse", pulses, 0);

        conv(4'd5, 4'd0, 4'd1, 501, 0, "post abort");

        @(negedge clk); #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd_to_bin.md
Name: bcd_to_bin

Overview:
- Converts a 3-digit packed BCD value (hundreds, tens, units) into a 10-bit unsigned binary value in the range 0..999.
- Sequential converter using the reverse double-dabble algorithm: shift right, then subtract 3 from each BCD digit that is 8 or more.
- Sits between decimal-entry/display logic and binary datapaths.
- Uses a valid/ready input handshake and a one-cycle output-valid pulse.

Parameters:
- None.
- Fixed localparams from the shared package: BCD_W = 12, BIN_W = 10, ITERS = 10.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  request to convert huns/tens/units this cycle.
- in_ready  output  1  converter idle; accepts a request.
- huns  input  4  hundreds digit, legal 0..9.
- tens  input  4  tens digit, legal 0..9.
- units  input  4  units digit, legal 0..9.
- Bout  output  10  binary result, held until the next result.
- out_valid  output  1  one-cycle pulse; Bout and err are new this cycle.
- err  output  1  set with out_valid if any accepted digit was greater than 9.

Behaviour:
- Reset (asynchronous on rst_n low): Bout=0, out_valid=0, err=0, in_ready=1, iteration counter=0, internal shift registers cleared.
- Acceptance: a request is accepted on a rising edge where in_valid=1 and in_ready=1. The digits are captured on that edge.
  - in_valid while in_ready=0 is ignored. No queuing.
- Capture:
  - bcd_reg = {huns, tens, units}; bin_reg = 0.
  - Invalid flag latched: any digit > 9.
  - in_ready drops on the same edge.
- Iteration (one per clock, ITERS=10 total):
  - {bcd_reg, bin_reg} is shifted right by 1.
  - Then each of the 3 BCD nibbles that is >= 8 has 3 subtracted.
  - Shift and adjust happen combinationally in the same cycle and are registered once.
- Completion: on the edge that performs iteration 10 (10 edges after the acceptance edge):
  - Bout <= bin_reg result, or 0 if the invalid flag is set.
  - err <= invalid flag.
  - out_valid <= 1 for exactly one cycle.
  - in_ready <= 1.
- Latency: out_valid is high in the 10th cycle after the acceptance edge.
- Throughput: one conversion per 11 cycles.
  - A new request may be accepted in the same cycle that out_valid is high, since in_ready is already 1.
- Hold: Bout and err hold their values between completions. out_valid is 0 except for the completion pulse.
- Arithmetic: valid inputs give exact results, Bout = 100*huns + 10*tens + units, maximum 999 (fits in 10 bits). No overflow is possible on legal inputs.
- Reset mid-conversion: the conversion is aborted, no out_valid is produced, and the block returns to the idle reset state.
- Inputs may change freely after acceptance without affecting the result.

Decomposition:
- Package bcd_to_bin_pkg:
  - BCD_W, BIN_W, ITERS, DIGIT_MAX=9, ADJ_THRESH=8, ADJ_VAL=3.
  - Typedef for a 4-bit BCD digit.
- Sub-module bcd_digit_adjust:
  - 4-bit combinational function: out = (in >= 8) ? in - 3 : in.
  - Instantiated 3 times inside bcd_to_bin.
- Control is a 2-state FSM (IDLE, BUSY) plus a 4-bit iteration counter.

Test Plan:
- huns=2, tens=0, units=0, pulse in_valid -> 10 cycles later out_valid=1, Bout=0011001000 (200), err=0.
- 9/9/9 -> Bout=1111100111 (999); 0/6/4 -> Bout=0001000000 (64); 0/9/5 -> Bout=0001011111 (95). Each has exactly 10-cycle latency and a single-cycle out_valid.
- 0/0/0 -> Bout=0, err=0, out_valid pulses.
- huns=0, tens=10, units=5 (invalid digit) -> out_valid=1, err=1, Bout=0. A following 1/2/3 request -> err=0, Bout=123.
- in_valid held high continuously across two different values:
  - Second value is accepted only in the out_valid cycle.
  - Mid-conversion changes to the inputs do not alter the result.
  - Results arrive 11 cycles apart.
- Assert rst_n low at iteration 5 of a 9/9/9 conversion -> all outputs go to 0 immediately, in_ready=1, and no out_valid pulse follows.
